// File: rtl/pum_mem_responder.sv
// ============================================================================
// Module   : pum_mem_responder
// Purpose  : Single-port row memory responder with a four-state request FSM,
//            programmable read latency and optional address range checking
//            (enable with `define PUM_MEM_RANGE_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pum_mem_responder #(
    parameter int DATA_W     = 1024,
    parameter int ADDR_W     = 14,
    parameter int DEPTH_LOG2 = 6,
    parameter int READ_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pum_mem_rd,
    input  logic              pum_mem_wr,
    input  logic [ADDR_W-1:0] pum_mem_addr,
    input  logic [DATA_W-1:0] pum_mem_wdata,
    output logic              pum_mem_ready,
    output logic              pum_mem_rvalid,
    output logic [DATA_W-1:0] pum_mem_rdata,
    output logic              pum_mem_wack,
    output logic              pum_mem_err
);

    localparam int c_depth = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RD_RESP = 2'd2,
        S_WR_ACK  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [2:0]              r_cnt;
    logic                    r_ready;
    logic                    r_rvalid;
    logic                    r_wack;
    logic                    r_err;
    logic [DATA_W-1:0]       r_rdata;
    logic [DEPTH_LOG2-1:0]   r_rd_idx;
    logic                    r_rd_oor;
    logic [DATA_W-1:0]       r_mem [0:c_depth-1];

    logic                    w_accept_rd;
    logic                    w_accept_wr;
    logic                    w_conflict;
    logic                    w_oor;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic [DATA_W-1:0]       w_row_now;
    logic [DATA_W-1:0]       w_row_held;

    assign w_idx = pum_mem_addr[DEPTH_LOG2-1:0];

`ifdef PUM_MEM_RANGE_CHECK_EN
    assign w_oor = ((pum_mem_addr >> DEPTH_LOG2) != '0);
`else
    // Upper address bits are deliberately ignored so rows alias modulo depth.
    logic w_addr_hi_unused;
    assign w_addr_hi_unused = |(pum_mem_addr >> DEPTH_LOG2);
    assign w_oor            = 1'b0;
`endif

    assign w_accept_rd = r_ready &&  pum_mem_rd && !pum_mem_wr;
    assign w_accept_wr = r_ready && !pum_mem_rd &&  pum_mem_wr;
    assign w_conflict  = r_ready &&  pum_mem_rd &&  pum_mem_wr;

    // Out-of-range reads respond with zeros; no write is accepted while a
    // read is outstanding, so reading the row at response time is equivalent
    // to reading it at acceptance.
    assign w_row_now  = w_oor    ? '0 : r_mem[w_idx];
    assign w_row_held = r_rd_oor ? '0 : r_mem[r_rd_idx];

    always_ff @(posedge clk) begin
        if (w_accept_wr && !w_oor) begin
            r_mem[w_idx] <= pum_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_ready  <= 1'b1;
            r_rvalid <= 1'b0;
            r_wack   <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_rd_idx <= '0;
            r_rd_oor <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_wack   <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept_rd) begin
                        r_rd_idx <= w_idx;
                        r_rd_oor <= w_oor;
                        r_ready  <= 1'b0;
                        if (READ_LAT == 1) begin
                            r_state  <= S_RD_RESP;
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_row_now;
                            r_err    <= w_oor;
                        end else begin
                            r_state <= S_RD_WAIT;
                            r_cnt   <= 3'(READ_LAT - 1);
                        end
                    end else if (w_accept_wr) begin
                        r_state <= S_WR_ACK;
                        r_ready <= 1'b0;
                        r_wack  <= 1'b1;
                        r_err   <= w_oor;
                    end else if (w_conflict) begin
                        r_err <= 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt <= 3'd1) begin
                        r_state  <= S_RD_RESP;
                        r_cnt    <= 3'd0;
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_row_held;
                        r_err    <= r_rd_oor;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RD_RESP: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                S_WR_ACK: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign pum_mem_ready  = r_ready;
    assign pum_mem_rvalid = r_rvalid;
    assign pum_mem_rdata  = r_rdata;
    assign pum_mem_wack   = r_wack;
    assign pum_mem_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pum_mem_responder.sv
// ============================================================================
// Module   : tb_pum_mem_responder
// Purpose  : Randomized self-checking bench for pum_mem_responder against a
//            transaction-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pum_mem_responder;

    localparam int DATA_W     = 1024;
    localparam int ADDR_W     = 14;
    localparam int DEPTH_LOG2 = 6;
    localparam int READ_LAT   = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              wack;
    logic              err;

    logic [DATA_W-1:0] mdl [DEPTH];
    logic [DATA_W-1:0] last_rdata;
    int                n_vectors = 0;
    int                n_miscompares = 0;

    pum_mem_responder #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH_LOG2(DEPTH_LOG2),
        .READ_LAT  (READ_LAT)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pum_mem_rd    (rd),
        .pum_mem_wr    (wr),
        .pum_mem_addr  (addr),
        .pum_mem_wdata (wdata),
        .pum_mem_ready (ready),
        .pum_mem_rvalid(rvalid),
        .pum_mem_rdata (rdata),
        .pum_mem_wack  (wack),
        .pum_mem_err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h (low 64 bits)", tag, act[63:0], exp[63:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_oor(input logic [ADDR_W-1:0] a);
`ifdef PUM_MEM_RANGE_CHECK_EN
        return (int'(a) >= DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] exp_row(input logic [ADDR_W-1:0] a);
        if (is_oor(a)) return '0;
        return mdl[int'(a) % DEPTH];
    endfunction

    function automatic logic [DATA_W-1:0] rand_row();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return ADDR_W'($urandom);
        return ADDR_W'($urandom_range(0, 2 * DEPTH - 1));
    endfunction

    task automatic drive_idle();
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic drive_junk();
        rd    = 1'($urandom);
        wr    = 1'($urandom);
        addr  = rand_addr();
        wdata = rand_row();
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        rd = 1'b0; wr = 1'b1; addr = a; wdata = d;
        chk("wr_ready_pre", ready, 1);
        tick();
        drive_idle();
        chk("wr_wack", wack, 1);
        chk("wr_err", err, is_oor(a));
        chk("wr_ready_busy", ready, 0);
        chk("wr_no_rvalid", rvalid, 0);
        tick();
        chk("wr_wack_end", wack, 0);
        chk("wr_ready_post", ready, 1);
        if (!is_oor(a)) mdl[int'(a) % DEPTH] = d;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] e;
        e = exp_row(a);
        rd = 1'b1; wr = 1'b0; addr = a;
        chk("rd_ready_pre", ready, 1);
        tick();
        for (int k = 1; k <= READ_LAT; k++) begin
            chk("rd_rvalid", rvalid, (k == READ_LAT));
            chk("rd_ready_busy", ready, 0);
            chk("rd_wack", wack, 0);
            chk("rd_err", err, (k == READ_LAT) ? is_oor(a) : 1'b0);
            if (k == READ_LAT) chk("rd_data", rdata, e);
            else chk("rd_data_held", rdata, last_rdata);
            if (k < READ_LAT) drive_junk();
            else drive_idle();
            tick();
        end
        chk("rd_ready_post", ready, 1);
        chk("rd_rvalid_end", rvalid, 0);
        chk("rd_data_retained", rdata, e);
        last_rdata = e;
    endtask

    task automatic do_conflict(input logic [ADDR_W-1:0] a);
        rd = 1'b1; wr = 1'b1; addr = a; wdata = rand_row();
        tick();
        drive_idle();
        chk("cf_err", err, 1);
        chk("cf_ready", ready, 1);
        chk("cf_wack", wack, 0);
        chk("cf_rvalid", rvalid, 0);
        chk("cf_rdata", rdata, last_rdata);
        tick();
        chk("cf_err_end", err, 0);
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
        rst_n = 1'b0;
        drive_idle();
        addr  = '0;
        wdata = '0;
        last_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_wack", wack, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), rand_row());

        // Write 0xA5 pattern to row 5 and read it back.
        d = {(DATA_W / 8){8'hA5}};
        do_write(ADDR_W'(5), d);
        do_read(ADDR_W'(5));

        // Two reads with rd held high across both acceptances.
        rd = 1'b1; wr = 1'b0; addr = ADDR_W'(0);
        tick();
        addr = ADDR_W'(1);
        chk("b2b_t1_rvalid", rvalid, 0);
        chk("b2b_t1_ready", ready, 0);
        tick();
        chk("b2b_t2_rvalid", rvalid, 1);
        chk("b2b_t2_rdata", rdata, mdl[0]);
        tick();
        chk("b2b_t3_ready", ready, 1);
        chk("b2b_t3_rvalid", rvalid, 0);
        tick();
        drive_idle();
        chk("b2b_t4_ready", ready, 0);
        chk("b2b_t4_rvalid", rvalid, 0);
        tick();
        chk("b2b_t5_rvalid", rvalid, 1);
        chk("b2b_t5_rdata", rdata, mdl[1]);
        tick();
        chk("b2b_t6_ready", ready, 1);
        last_rdata = mdl[1];

        // Conflicting request on row 3 must leave it untouched.
        do_conflict(ADDR_W'(3));
        do_read(ADDR_W'(3));

        // Out-of-range read after writing row 0.
        do_write(ADDR_W'(0), DATA_W'(1));
        do_read(ADDR_W'(64));

        // Reset one cycle after a read is accepted.
        d = mdl[7];
        rd = 1'b1; wr = 1'b0; addr = ADDR_W'(7);
        tick();
        drive_idle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= READ_LAT + 1; k++) begin
            tick();
            chk("mid_rst_no_rvalid", rvalid, 0);
            chk("mid_rst_ready_post", ready, 1);
            chk("mid_rst_rdata_post", rdata, 0);
        end
        last_rdata = '0;
        do_read(ADDR_W'(7));
        chk("storage_kept", last_rdata, d);

        for (int n = 0; n < 300; n++) begin
            a = rand_addr();
            case ($urandom_range(0, 9))
                0, 1, 2, 3: do_write(a, rand_row());
                4, 5, 6, 7: do_read(a);
                8:          do_conflict(a);
                default: begin
                    drive_idle();
                    tick();
                    chk("idle_err", err, 0);
                    chk("idle_ready", ready, 1);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

`default_nettype wire
